condicionador_botoes: RTL and testbench

Input conditioner for the four game buttons, placed between the board push-buttons and the `botoes` input of the game top level. It synchronises the raw asynchronous buttons, debounces press and release with a programmable filter, and rejects simultaneous multi-button presses. It delivers a clean, held one-hot button code plus a single-cycle `jogada_pulso` per accepted press.

---
 rtl/condicionador_botoes.sv | 101 ++++++++++
 tb/tb_condicionador_botoes.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// Button conditioner: 2-flop synchroniser, press/release debounce filter and
// multi-button rejection, producing a held one-hot code plus a press pulse.
module condicionador_botoes #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  output logic [3:0] botoes,
  output logic       jogada_pulso,
  output logic       multiplo,
  output logic [1:0] db_estado
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  estado_t       estado;
  logic [3:0]    meta;
  logic [3:0]    sinc;
  logic [3:0]    candidato;
  logic [CW-1:0] cnt;
  logic          um_quente;

  assign um_quente = (candidato != 4'b0000) &&
                     ((candidato & (candidato - 4'd1)) == 4'b0000);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta         <= '0;
      sinc         <= '0;
      candidato    <= '0;
      cnt          <= '0;
      estado       <= OCIOSO;
      botoes       <= '0;
      jogada_pulso <= 1'b0;
      multiplo     <= 1'b0;
    end else begin
      meta         <= botoes_in;
      sinc         <= meta;
      jogada_pulso <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (sinc != 4'b0000) begin
            candidato <= sinc;
            cnt       <= '0;
            estado    <= FILTRANDO;
          end
        end
        FILTRANDO: begin
          // A sinc change wins over a counter that has just reached its limit.
          if (sinc == 4'b0000) begin
            estado <= OCIOSO;
          end else if (sinc != candidato) begin
            candidato <= sinc;
            cnt       <= '0;
          end else if (cnt == CNT_MAX) begin
            estado <= PRESSIONADO;
            if (um_quente) begin
              botoes       <= candidato;
              jogada_pulso <= 1'b1;
            end else begin
              botoes   <= '0;
              multiplo <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSIONADO: begin
          if (sinc == 4'b0000) begin
            cnt    <= '0;
            estado <= SOLTANDO;
          end
        end
        SOLTANDO: begin
          if (sinc != 4'b0000) begin
            estado <= PRESSIONADO;
          end else if (cnt == CNT_MAX) begin
            botoes   <= '0;
            multiplo <= 1'b0;
            estado   <= OCIOSO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CYCLES=4: a clean
// press shows its pulse 7 edges after the raw change, a release clears 7 edges later.
module tb_condicionador_botoes;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_in;
  logic [3:0] botoes;
  logic       jogada_pulso;
  logic       multiplo;
  logic [1:0] db_estado;

  int checks;
  int errors;

  condicionador_botoes #(.DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .botoes_in   (botoes_in),
    .botoes      (botoes),
    .jogada_pulso(jogada_pulso),
    .multiplo    (multiplo),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_all();
    botoes_in = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    botoes_in = 4'b0010;
    repeat (5) tick();
    checks++;
    if (botoes !== 4'b0000 || jogada_pulso !== 1'b0 || multiplo !== 1'b0 || db_estado !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold botoes=%b pulso=%b multiplo=%b estado=%0d required 0000 0 0 0",
               botoes, jogada_pulso, multiplo, db_estado);
    end
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (jogada_pulso !== (k == 7)) begin
        errors++;
        $display("FAIL reset_pulse edge=%0d pulso=%b required %b", k, jogada_pulso, k == 7);
      end
      checks++;
      if (botoes !== ((k >= 7) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL reset_botoes edge=%0d botoes=%b required %b", k, botoes,
                 (k >= 7) ? 4'b0010 : 4'b0000);
      end
    end
    // asynchronous assertion mid-press clears immediately
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (botoes !== 4'b0000 || db_estado !== 2'd0) begin
      errors++;
      $display("FAIL reset_async botoes=%b estado=%0d required 0000 0", botoes, db_estado);
    end
    botoes_in = 4'b0000;
    tick();
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clean_press();
    int pulses;
    pulses = 0;
    botoes_in = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (jogada_pulso === 1'b1) pulses++;
      checks++;
      if (jogada_pulso !== (k == 7)) begin
        errors++;
        $display("FAIL clean_pulse edge=%0d pulso=%b required %b", k, jogada_pulso, k == 7);
      end
      checks++;
      if (botoes !== ((k >= 7) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL clean_botoes edge=%0d botoes=%b required %b", k, botoes,
                 (k >= 7) ? 4'b0100 : 4'b0000);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL clean_pulse_count got=%0d required 1", pulses);
    end
    botoes_in = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (botoes !== ((k < 7) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL release_botoes edge=%0d botoes=%b required %b", k, botoes,
                 (k < 7) ? 4'b0100 : 4'b0000);
      end
      if (k == 3) begin
        checks++;
        if (db_estado !== 2'd3) begin
          errors++;
          $display("FAIL release_soltando estado=%0d required 3", db_estado);
        end
      end
      if (k == 7) begin
        checks++;
        if (db_estado !== 2'd0) begin
          errors++;
          $display("FAIL release_ocioso estado=%0d required 0", db_estado);
        end
      end
    end
  endtask

  task automatic test_press_bounce();
    for (int k = 1; k <= 10; k++) begin
      botoes_in = ((((k - 1) / 2) % 2) == 0) ? 4'b0000 : 4'b0001;
      tick();
      checks++;
      if (jogada_pulso !== 1'b0 || botoes !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_toggle edge=%0d pulso=%b botoes=%b required 0 0000",
                 k, jogada_pulso, botoes);
      end
    end
    botoes_in = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (jogada_pulso !== (k == 7)) begin
        errors++;
        $display("FAIL bounce_pulse edge=%0d pulso=%b required %b", k, jogada_pulso, k == 7);
      end
    end
    checks++;
    if (botoes !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_botoes botoes=%b required 0001", botoes);
    end
    release_all();
  endtask

  task automatic test_release_bounce();
    logic [3:0] glitch [6];
    glitch = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b1000};
    botoes_in = 4'b1000;
    repeat (8) tick();
    checks++;
    if (botoes !== 4'b1000) begin
      errors++;
      $display("FAIL relb_press botoes=%b required 1000", botoes);
    end
    for (int k = 0; k < 6; k++) begin
      botoes_in = glitch[k];
      tick();
      checks++;
      if (botoes !== 4'b1000 || jogada_pulso !== 1'b0) begin
        errors++;
        $display("FAIL relb_glitch step=%0d botoes=%b pulso=%b required 1000 0",
                 k, botoes, jogada_pulso);
      end
    end
    botoes_in = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (botoes !== ((k < 7) ? 4'b1000 : 4'b0000) || jogada_pulso !== 1'b0) begin
        errors++;
        $display("FAIL relb_final edge=%0d botoes=%b pulso=%b required %b 0", k, botoes,
                 jogada_pulso, (k < 7) ? 4'b1000 : 4'b0000);
      end
    end
  endtask

  task automatic test_multiple();
    botoes_in = 4'b0011;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (multiplo !== (k >= 7) || botoes !== 4'b0000 || jogada_pulso !== 1'b0) begin
        errors++;
        $display("FAIL multi_press edge=%0d multiplo=%b botoes=%b pulso=%b required %b 0000 0",
                 k, multiplo, botoes, jogada_pulso, k >= 7);
      end
    end
    botoes_in = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (multiplo !== (k < 7)) begin
        errors++;
        $display("FAIL multi_release edge=%0d multiplo=%b required %b", k, multiplo, k < 7);
      end
    end
  endtask

  task automatic test_change_held();
    botoes_in = 4'b0001;
    repeat (8) tick();
    botoes_in = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (botoes !== 4'b0001 || jogada_pulso !== 1'b0) begin
        errors++;
        $display("FAIL held_change edge=%0d botoes=%b pulso=%b required 0001 0",
                 k, botoes, jogada_pulso);
      end
    end
    release_all();
    checks++;
    if (botoes !== 4'b0000 || db_estado !== 2'd0) begin
      errors++;
      $display("FAIL held_release botoes=%b estado=%0d required 0000 0", botoes, db_estado);
    end
    botoes_in = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (jogada_pulso !== (k == 7)) begin
        errors++;
        $display("FAIL held_new_pulse edge=%0d pulso=%b required %b", k, jogada_pulso, k == 7);
      end
    end
    checks++;
    if (botoes !== 4'b0010) begin
      errors++;
      $display("FAIL held_new_botoes botoes=%b required 0010", botoes);
    end
    release_all();
  endtask

  task automatic test_boundary();
    // sinc changes exactly when cnt sits at its limit: no acceptance, window restarts
    botoes_in = 4'b0001;
    repeat (4) tick();
    botoes_in = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (jogada_pulso !== (k == 7)) begin
        errors++;
        $display("FAIL boundary_pulse edge=%0d pulso=%b required %b", k, jogada_pulso, k == 7);
      end
      checks++;
      if (botoes !== ((k >= 7) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL boundary_botoes edge=%0d botoes=%b required %b", k, botoes,
                 (k >= 7) ? 4'b0010 : 4'b0000);
      end
    end
    release_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    botoes_in = 4'b0000;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_multiple();
    test_change_held();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
